// File: rtl/uart_transmitter_if.sv
// Character-request and serial-output signals between the transmit holding logic and the UART transmitter.
// The master drives characters, line control and the baud tick; the slave returns SOUT and the end-of-frame pulse.
interface uart_transmitter_if;
    logic       TXCLK;
    logic       CLEAR;
    logic       TXSTART;
    logic [7:0] DIN;
    logic [1:0] WLS;
    logic       STB;
    logic       PEN;
    logic       EPS;
    logic       SP;
    logic       BC;
    logic       SOUT;
    logic       TXFINISHED;

    modport master (
        output TXCLK, CLEAR, TXSTART, DIN, WLS, STB, PEN, EPS, SP, BC,
        input  SOUT, TXFINISHED
    );

    modport slave (
        input  TXCLK, CLEAR, TXSTART, DIN, WLS, STB, PEN, EPS, SP, BC,
        output SOUT, TXFINISHED
    );
endinterface

// File: rtl/uart_transmitter.sv
// 16550-style UART transmitter: start, 5-8 data bits LSB first, optional parity, 1/1.5/2 stop bits, break.
// Every advance happens on a 16x baud tick; SOUT and TXFINISHED are registered.
module uart_transmitter (
    input  logic              CLK,
    input  logic              RST,
    uart_transmitter_if.slave tx
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic [7:0] word_mask(input logic [1:0] wls);
        case (wls)
            2'b00:   word_mask = 8'h1F;
            2'b01:   word_mask = 8'h3F;
            2'b10:   word_mask = 8'h7F;
            default: word_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic [2:0] last_index(input logic [1:0] wls);
        last_index = 3'd4 + {1'b0, wls};
    endfunction

    // Stick parity overrides; otherwise even = XOR, odd = XNOR over the sent bits only.
    function automatic logic parity_bit(input logic [7:0] din, input logic [1:0] wls,
                                        input logic eps, input logic sp);
        logic ones_odd;
        ones_odd = ^(din & word_mask(wls));
        if (sp) begin
            parity_bit = ~eps;
        end else if (eps) begin
            parity_bit = ones_odd;
        end else begin
            parity_bit = ~ones_odd;
        end
    endfunction

    state_t     state_r, state_s;
    logic [3:0] tick_cnt_r, tick_cnt_s;
    logic [2:0] bit_idx_r, bit_idx_s;
    logic       stop_half_r, stop_half_s;
    logic [7:0] din_r, din_s;
    logic [1:0] wls_r, wls_s;
    logic       stb_r, stb_s;
    logic       pen_r, pen_s;
    logic       eps_r, eps_s;
    logic       sp_r, sp_s;
    logic       sout_r, sout_s;
    logic       txfinished_r, finished_s;
    logic       line_s;
    logic       tick_last_s;
    logic       stop_done_s;

    assign tick_last_s = (tick_cnt_r == 4'd15);

    // Long stop runs a second 16-tick phase, cut to 8 ticks for the 1.5-stop case.
    assign stop_done_s = !stb_r       ? tick_last_s :
                         !stop_half_r ? 1'b0 :
                         (wls_r == 2'b00) ? (tick_cnt_r == 4'd7) : tick_last_s;

    // Next-state, counter and character-latch logic.
    always_comb begin
        state_s     = state_r;
        tick_cnt_s  = tick_cnt_r;
        bit_idx_s   = bit_idx_r;
        stop_half_s = stop_half_r;
        din_s       = din_r;
        wls_s       = wls_r;
        stb_s       = stb_r;
        pen_s       = pen_r;
        eps_s       = eps_r;
        sp_s        = sp_r;
        finished_s  = 1'b0;
        if (tx.CLEAR) begin
            state_s     = IDLE;
            tick_cnt_s  = 4'd0;
            bit_idx_s   = 3'd0;
            stop_half_s = 1'b0;
        end else if (tx.TXCLK) begin
            case (state_r)
                IDLE: begin
                    if (tx.TXSTART) begin
                        din_s      = tx.DIN;
                        wls_s      = tx.WLS;
                        stb_s      = tx.STB;
                        pen_s      = tx.PEN;
                        eps_s      = tx.EPS;
                        sp_s       = tx.SP;
                        tick_cnt_s = 4'd0;
                        state_s    = START;
                    end else begin
                        state_s    = IDLE;
                    end
                end
                START: begin
                    if (tick_last_s) begin
                        tick_cnt_s = 4'd0;
                        bit_idx_s  = 3'd0;
                        state_s    = DATA;
                    end else begin
                        tick_cnt_s = tick_cnt_r + 4'd1;
                    end
                end
                DATA: begin
                    if (tick_last_s) begin
                        tick_cnt_s = 4'd0;
                        if (bit_idx_r == last_index(wls_r)) begin
                            state_s     = pen_r ? PARITY : STOP;
                            stop_half_s = 1'b0;
                        end else begin
                            bit_idx_s   = bit_idx_r + 3'd1;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + 4'd1;
                    end
                end
                PARITY: begin
                    if (tick_last_s) begin
                        tick_cnt_s  = 4'd0;
                        stop_half_s = 1'b0;
                        state_s     = STOP;
                    end else begin
                        tick_cnt_s  = tick_cnt_r + 4'd1;
                    end
                end
                STOP: begin
                    if (stop_done_s) begin
                        tick_cnt_s  = 4'd0;
                        stop_half_s = 1'b0;
                        state_s     = IDLE;
                        finished_s  = 1'b1;
                    end else if (tick_last_s) begin
                        tick_cnt_s  = 4'd0;
                        stop_half_s = 1'b1;
                    end else begin
                        tick_cnt_s  = tick_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_s    = IDLE;
                    tick_cnt_s = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Line level of the state being entered, so SOUT moves on the same edge as the state.
    always_comb begin
        line_s = 1'b1;
        case (state_s)
            IDLE:    line_s = 1'b1;
            START:   line_s = 1'b0;
            DATA:    line_s = din_s[bit_idx_s];
            PARITY:  line_s = parity_bit(din_s, wls_s, eps_s, sp_s);
            STOP:    line_s = 1'b1;
            default: line_s = 1'b1;
        endcase
        if (tx.BC) begin
            sout_s = 1'b0;
        end else begin
            sout_s = line_s;
        end
    end

    // State, latched character and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            tick_cnt_r   <= 4'd0;
            bit_idx_r    <= 3'd0;
            stop_half_r  <= 1'b0;
            din_r        <= 8'h00;
            wls_r        <= 2'b00;
            stb_r        <= 1'b0;
            pen_r        <= 1'b0;
            eps_r        <= 1'b0;
            sp_r         <= 1'b0;
            sout_r       <= 1'b1;
            txfinished_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            tick_cnt_r   <= tick_cnt_s;
            bit_idx_r    <= bit_idx_s;
            stop_half_r  <= stop_half_s;
            din_r        <= din_s;
            wls_r        <= wls_s;
            stb_r        <= stb_s;
            pen_r        <= pen_s;
            eps_r        <= eps_s;
            sp_r         <= sp_s;
            sout_r       <= sout_s;
            txfinished_r <= finished_s;
        end
    end

    assign tx.SOUT       = sout_r;
    assign tx.TXFINISHED = txfinished_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: table of line-control vectors expanded into a per-tick expected waveform
// queue, plus hand-written break, CLEAR and reset sequences.
module tb_uart_transmitter;
    logic clk = 1'b0;
    logic rst;

    uart_transmitter_if tx_if ();

    uart_transmitter dut (
        .CLK (clk),
        .RST (rst),
        .tx  (tx_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic sout;
        logic fin;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic [1:0] wls;
        logic       stb;
        logic       pen;
        logic       eps;
        logic       sp;
        logic       exp_par;
        int         exp_ticks;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[10];
    int   errors = 0;
    int   checks = 0;
    int   tick_no = 0;
    logic bc_level = 1'b0;

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s tick=%0d got=%0b expected=%0b", name, tick_no, act, req);
        end
    endtask

    task automatic push_seg(input logic sout, input logic fin, input int count);
        exp_t e;
        e.sout = sout;
        e.fin  = fin;
        for (int k = 0; k < count; k++) exp_q.push_back(e);
    endtask

    // Expected line after each tick: accept tick enters START, final stop tick returns to idle with the pulse.
    task automatic push_frame(input vec_t v);
        int n;
        int stop_len;
        n = int'(v.wls) + 5;
        push_seg(1'b0, 1'b0, 16);
        for (int i = 0; i < n; i++) push_seg(v.din[i], 1'b0, 16);
        if (v.pen) push_seg(v.exp_par, 1'b0, 16);
        stop_len = v.exp_ticks - 16 * (1 + n + (v.pen ? 1 : 0));
        push_seg(1'b1, 1'b0, stop_len);
        push_seg(1'b1, 1'b1, 1);
    endtask

    task automatic do_tick();
        exp_t e;
        e.sout = 1'b1;
        e.fin  = 1'b0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        @(negedge clk) tx_if.TXCLK = 1'b1;
        @(posedge clk) #1;
        check_bit("sout_tick", tx_if.SOUT, bc_level ? 1'b0 : e.sout);
        check_bit("finished_tick", tx_if.TXFINISHED, e.fin);
        @(negedge clk) tx_if.TXCLK = 1'b0;
        @(posedge clk) #1;
        check_bit("sout_hold", tx_if.SOUT, bc_level ? 1'b0 : e.sout);
        check_bit("finished_single", tx_if.TXFINISHED, 1'b0);
        @(negedge clk);
        @(negedge clk);
        tick_no++;
    endtask

    task automatic drive_vec(input vec_t v);
        tx_if.DIN     = v.din;
        tx_if.WLS     = v.wls;
        tx_if.STB     = v.stb;
        tx_if.PEN     = v.pen;
        tx_if.EPS     = v.eps;
        tx_if.SP      = v.sp;
        tx_if.TXSTART = 1'b1;
    endtask

    task automatic scramble_vec(input vec_t v);
        tx_if.DIN = ~v.din;
        tx_if.WLS = ~v.wls;
        tx_if.STB = ~v.stb;
        tx_if.PEN = ~v.pen;
        tx_if.EPS = ~v.eps;
        tx_if.SP  = ~v.sp;
    endtask

    // Accept on one tick, then corrupt the inputs for the rest of the frame.
    task automatic send_frame(input vec_t v);
        drive_vec(v);
        push_frame(v);
        do_tick();
        scramble_vec(v);
        repeat (v.exp_ticks) do_tick();
    endtask

    task automatic abort_test(input logic use_rst);
        vec_t z;
        vec_t nx;
        z  = '{8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 160};
        nx = '{8'h5A, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 176};
        drive_vec(z);
        push_frame(z);
        do_tick();
        repeat (52) do_tick();
        if (use_rst) rst = 1'b1;
        else tx_if.CLEAR = 1'b1;
        @(posedge clk) #1;
        check_bit(use_rst ? "sout_after_rst" : "sout_after_clear", tx_if.SOUT, 1'b1);
        check_bit(use_rst ? "fin_after_rst" : "fin_after_clear", tx_if.TXFINISHED, 1'b0);
        rst = 1'b0;
        tx_if.CLEAR = 1'b0;
        exp_q.delete();
        send_frame(nx);
    endtask

    initial begin
        vec_t bv;
        rst           = 1'b1;
        tx_if.TXCLK   = 1'b0;
        tx_if.CLEAR   = 1'b0;
        tx_if.TXSTART = 1'b0;
        tx_if.DIN     = 8'h00;
        tx_if.WLS     = 2'b00;
        tx_if.STB     = 1'b0;
        tx_if.PEN     = 1'b0;
        tx_if.EPS     = 1'b0;
        tx_if.SP      = 1'b0;
        tx_if.BC      = 1'b0;

        //          din    wls    stb   pen   eps   sp    par   ticks
        vecs[0] = '{8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 160};
        vecs[1] = '{8'hE3, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 136};
        vecs[2] = '{8'h00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 160};
        vecs[3] = '{8'h00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 176};
        vecs[4] = '{8'hA7, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 144};
        vecs[5] = '{8'h3C, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 192};
        vecs[6] = '{8'h1F, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 128};
        vecs[7] = '{8'h80, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 176};
        vecs[8] = '{8'h7F, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 160};
        vecs[9] = '{8'hFE, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 120};

        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_sout", tx_if.SOUT, 1'b1);
        check_bit("reset_finished", tx_if.TXFINISHED, 1'b0);
        @(negedge clk) rst = 1'b0;
        repeat (2) do_tick();

        // Even entries run straight into the next frame with TXSTART held.
        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i]);
            if (i % 2 == 1) begin
                tx_if.TXSTART = 1'b0;
                repeat (2) do_tick();
            end
        end

        // Break asserted inside the first data bit of 0xFF, released mid-bit.
        bv = '{8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 160};
        drive_vec(bv);
        push_frame(bv);
        do_tick();
        repeat (20) do_tick();
        tx_if.BC = 1'b1;
        bc_level = 1'b1;
        @(posedge clk) #1;
        check_bit("break_on", tx_if.SOUT, 1'b0);
        repeat (10) do_tick();
        tx_if.BC = 1'b0;
        bc_level = 1'b0;
        @(posedge clk) #1;
        check_bit("break_off", tx_if.SOUT, 1'b1);
        repeat (130) do_tick();
        tx_if.TXSTART = 1'b0;
        repeat (2) do_tick();

        abort_test(1'b0);
        abort_test(1'b1);
        tx_if.TXSTART = 1'b0;
        repeat (3) do_tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
